// File: rtl/tile_stimulus_probe_if.sv
// Pin-level bundle between a run controller and the tile stimulus probe.
// master = controller side (start/abort, tile response); slave = the probe.
interface tile_stimulus_probe_if;
    logic        start;
    logic        abort;
    logic [7:0]  tile_uo;
    logic [7:0]  tile_ui;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic [7:0]  vec_idx;

    modport master (
        output start, abort, tile_uo,
        input  tile_ui, busy, done, signature, vec_idx
    );

    modport slave (
        input  start, abort, tile_uo,
        output tile_ui, busy, done, signature, vec_idx
    );
endinterface

// File: rtl/tile_stimulus_probe.sv
// Purpose: drives LFSR vectors onto a microtile's inputs and folds its outputs into a 16-bit MISR.
// Latency: done rises NUM_VECTORS*(SETTLE_CYCLES+1) edges after the edge that captures start.
// Backpressure: none; start is ignored while busy, abort wins over start and over a sample edge.
module tile_stimulus_probe #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NUM_VECTORS   = 16,
    parameter logic [7:0]  SEED          = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tile_stimulus_probe_if.slave   bus
);

    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [7:0] SEED_EFF    = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);
    localparam logic [7:0] LAST_IDX    = 8'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  settle_cnt;
    logic [7:0]  lfsr;
    logic [7:0]  tile_ui_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] sig_q;
    logic [7:0]  vec_idx_q;

    logic [7:0]  lfsr_next;
    logic [15:0] misr_next;

    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign misr_next = {sig_q[14:0], sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3]}
                       ^ {8'h00, bus.tile_uo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            lfsr       <= SEED_EFF;
            tile_ui_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sig_q      <= '0;
            vec_idx_q  <= '0;
        end else if (bus.abort) begin
            // Signature and index are left intact so a partial run can be inspected.
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tile_ui_q <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state      <= SETTLE;
                        lfsr       <= SEED_EFF;
                        tile_ui_q  <= SEED_EFF;
                        sig_q      <= '0;
                        vec_idx_q  <= '0;
                        settle_cnt <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != SETTLE_LAST) begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end else begin
                        sig_q <= misr_next;
                        if (vec_idx_q == LAST_IDX) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            lfsr       <= lfsr_next;
                            tile_ui_q  <= lfsr_next;
                            vec_idx_q  <= vec_idx_q + 8'd1;
                            settle_cnt <= '0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tile_ui   = tile_ui_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.signature = sig_q;
    assign bus.vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_tile_stimulus_probe.sv
// Exercises four probe builds side by side (N=1, N=2 loopback, N=16 LUT tile, SEED=0 N=3 S=0)
// against a vector-list/MISR reference computed directly from the run rules.
module tb_tile_stimulus_probe;

    logic clk;
    logic rst_n;
    logic start;
    logic abort;
    logic [7:0] uo_a;
    logic [7:0] lut_c [256];

    tile_stimulus_probe_if bus_a ();
    tile_stimulus_probe_if bus_b ();
    tile_stimulus_probe_if bus_c ();
    tile_stimulus_probe_if bus_d ();

    assign bus_a.start = start;  assign bus_a.abort = abort;
    assign bus_b.start = start;  assign bus_b.abort = abort;
    assign bus_c.start = start;  assign bus_c.abort = abort;
    assign bus_d.start = start;  assign bus_d.abort = abort;

    assign bus_a.tile_uo = uo_a;
    assign bus_b.tile_uo = bus_b.tile_ui;
    assign bus_c.tile_uo = lut_c[bus_c.tile_ui];
    assign bus_d.tile_uo = bus_d.tile_ui;

    tile_stimulus_probe #(.SETTLE_CYCLES(2), .NUM_VECTORS(1),  .SEED(8'hA5))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    tile_stimulus_probe #(.SETTLE_CYCLES(2), .NUM_VECTORS(2),  .SEED(8'hA5))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    tile_stimulus_probe #(.SETTLE_CYCLES(2), .NUM_VECTORS(16), .SEED(8'hA5))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));
    tile_stimulus_probe #(.SETTLE_CYCLES(0), .NUM_VECTORS(3),  .SEED(8'h00))
        dut_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));

    logic [7:0]  ui_now   [4];
    logic        busy_now [4];
    logic        done_now [4];
    logic [15:0] sig_now  [4];
    logic [7:0]  idx_now  [4];

    assign ui_now[0] = bus_a.tile_ui;  assign busy_now[0] = bus_a.busy;  assign done_now[0] = bus_a.done;
    assign ui_now[1] = bus_b.tile_ui;  assign busy_now[1] = bus_b.busy;  assign done_now[1] = bus_b.done;
    assign ui_now[2] = bus_c.tile_ui;  assign busy_now[2] = bus_c.busy;  assign done_now[2] = bus_c.done;
    assign ui_now[3] = bus_d.tile_ui;  assign busy_now[3] = bus_d.busy;  assign done_now[3] = bus_d.done;
    assign sig_now[0] = bus_a.signature;  assign idx_now[0] = bus_a.vec_idx;
    assign sig_now[1] = bus_b.signature;  assign idx_now[1] = bus_b.vec_idx;
    assign sig_now[2] = bus_c.signature;  assign idx_now[2] = bus_c.vec_idx;
    assign sig_now[3] = bus_d.signature;  assign idx_now[3] = bus_d.vec_idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int         done_at [4];
    int         busy_n  [4];
    logic [7:0] ui_tr   [4][128];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---- reference model: build parameters and run rules ----
    function automatic int nv(input int d);
        case (d)
            0: return 1;
            1: return 2;
            2: return 16;
            default: return 3;
        endcase
    endfunction

    function automatic int sc(input int d);
        return (d == 3) ? 0 : 2;
    endfunction

    function automatic logic [7:0] first_vec(input int d);
        return (d == 3) ? 8'h01 : 8'hA5;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [7:0] uo);
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {8'h00, uo};
    endfunction

    function automatic logic [7:0] model_vec(input int d, input int i);
        logic [7:0] v;
        v = first_vec(d);
        for (int j = 0; j < i; j++) v = lfsr_step(v);
        return v;
    endfunction

    function automatic logic [7:0] uo_of(input int d, input logic [7:0] v);
        case (d)
            0: return uo_a;
            2: return lut_c[v];
            default: return v;
        endcase
    endfunction

    function automatic logic [15:0] model_sig(input int d);
        logic [15:0] s;
        s = 16'h0000;
        for (int i = 0; i < nv(d); i++) s = misr(s, uo_of(d, model_vec(d, i)));
        return s;
    endfunction

    function automatic logic [15:0] sig_const16(input logic [7:0] uo);
        logic [15:0] s;
        s = 16'h0000;
        for (int i = 0; i < 16; i++) s = misr(s, uo);
        return s;
    endfunction

    // ---- run driver: pulse (or hold) start, trace every build until each is done ----
    task automatic do_run(input bit hold);
        bit all_done;
        for (int d = 0; d < 4; d++) begin
            done_at[d] = -1;
            busy_n[d]  = 0;
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = hold;
        for (int k = 0; k < 120; k++) begin
            all_done = 1'b1;
            for (int d = 0; d < 4; d++) begin
                if (done_at[d] < 0) begin
                    if (busy_now[d] && busy_n[d] < 128) begin
                        ui_tr[d][busy_n[d]] = ui_now[d];
                        busy_n[d]++;
                    end
                    if (done_now[d]) done_at[d] = k;
                    else all_done = 1'b0;
                end
            end
            if (all_done) break;
            @(negedge clk);
        end
    endtask

    task automatic check_run(input int d, input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < busy_n[d]; k++)
            if (ui_tr[d][k] !== model_vec(d, k / (sc(d) + 1))) bad++;
        check({tag, "_done_latency"}, done_at[d], nv(d) * (sc(d) + 1));
        check({tag, "_busy_cycles"}, busy_n[d], nv(d) * (sc(d) + 1));
        check({tag, "_ui_sequence_errors"}, bad, 0);
        check({tag, "_signature"}, sig_now[d], model_sig(d));
        check({tag, "_vec_idx"}, idx_now[d], nv(d) - 1);
    endtask

    task automatic check_quiet(input int d, input string tag);
        check({tag, "_busy"}, busy_now[d], 0);
        check({tag, "_done"}, done_now[d], 0);
        check({tag, "_tile_ui"}, ui_now[d], 0);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  uo;
        logic [15:0] exp_a;
        logic [15:0] exp_c;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [7:0] r;
        r = 8'($urandom_range(1, 255));
        tbl[0] = '{"uo_3c",   8'h3C, 16'h003C, sig_const16(8'h3C)};
        tbl[1] = '{"uo_00",   8'h00, 16'h0000, 16'h0000};
        tbl[2] = '{"uo_ff",   8'hFF, 16'h00FF, sig_const16(8'hFF)};
        tbl[3] = '{"uo_81",   8'h81, 16'h0081, sig_const16(8'h81)};
        tbl[4] = '{"uo_rand", r,     {8'h00, r}, sig_const16(r)};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        uo_a  = 8'h3C;
        for (int i = 0; i < 256; i++) lut_c[i] = 8'h00;

        #12;
        for (int d = 0; d < 4; d++) begin
            check_quiet(d, "in_reset");
            check("in_reset_signature", sig_now[d], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_quiet(2, "idle20");
        check("idle20_signature", sig_now[2], 0);
        check("idle20_vec_idx", idx_now[2], 0);

        // Constant tile responses.
        for (int t = 0; t < 5; t++) begin
            uo_a = tbl[t].uo;
            for (int i = 0; i < 256; i++) lut_c[i] = tbl[t].uo;
            do_run(1'b0);
            check({tbl[t].name, "_sig_n1"},  sig_now[0], tbl[t].exp_a);
            check({tbl[t].name, "_sig_n16"}, sig_now[2], tbl[t].exp_c);
            check({tbl[t].name, "_busy_n16"}, busy_n[2], 48);
            if (t == 0) begin
                check("n1_ui_first", ui_tr[0][0], 8'hA5);
                check("n1_ui_last",  ui_tr[0][2], 8'hA5);
                check("loop_ui_v0",  ui_tr[1][0], 8'hA5);
                check("loop_ui_v1",  ui_tr[1][3], 8'h4A);
                check("loop_sig",    sig_now[1], 16'h0100);
                check("loop_done",   done_at[1], 6);
                check("seed0_first", ui_tr[3][0], 8'h01);
                for (int d = 0; d < 4; d++) check_run(d, "const");
            end
        end

        // Random tiles.
        for (int n = 0; n < 4; n++) begin
            uo_a = 8'($urandom);
            for (int i = 0; i < 256; i++) lut_c[i] = 8'($urandom);
            do_run(1'b0);
            for (int d = 0; d < 4; d++) check_run(d, "rand");
        end

        // Abort on the 4th cycle of a run.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int d = 0; d < 4; d++) check_quiet(d, "abort");
        check("abort_keeps_sig",  sig_now[1], {8'h00, 8'hA5});
        check("abort_keeps_idx",  idx_now[1], 1);
        check("abort_keeps_done_sig", sig_now[0], {8'h00, uo_a});

        // abort beats start on the same edge.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_quiet(2, "abort_vs_start");
        do_run(1'b0);
        for (int d = 0; d < 4; d++) check_run(d, "after_abort");

        // Asynchronous reset mid-run.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            check_quiet(d, "midrun_reset");
            check("midrun_reset_sig", sig_now[d], 0);
            check("midrun_reset_idx", idx_now[d], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_run(1'b0);
        for (int d = 0; d < 4; d++) check_run(d, "after_reset");

        // start held high: one run, then immediate restart from DONE.
        do_run(1'b1);
        check_run(2, "held_start");
        @(negedge clk);
        start = 1'b0;
        check("restart_busy", busy_now[2], 1);
        check("restart_done", done_now[2], 0);
        check("restart_ui",   ui_now[2], 8'hA5);
        for (int k = 0; k < 200; k++) begin
            if (done_now[2]) break;
            @(negedge clk);
        end
        check("restart_completes", done_now[2], 1);
        check("restart_sig", sig_now[2], model_sig(2));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
